// File: rtl/prog_check_pkg.sv
// prog_check_pkg: shared types and helpers for the program check sequencer.
// Holds the sequencer state enum, the address window struct and sat_inc.
package prog_check_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LAUNCH = 3'd1,
    S_RUN    = 3'd2,
    S_CHECK  = 3'd3,
    S_DRAIN  = 3'd4,
    S_NEXT   = 3'd5,
    S_FIN    = 3'd6
  } seq_state_t;

  localparam int RANGE_W = 32;

  typedef struct packed {
    logic [RANGE_W-1:0] lo;
    logic [RANGE_W-1:0] hi;
  } range_t;

  // Increment v, holding at the all-ones value of a w-bit counter.
  function automatic logic [31:0] sat_inc(
    input logic [31:0] v,
    input int unsigned w
  );
    logic [31:0] m;
    m = (w >= 32) ? '1 : ((32'd1 << w) - 32'd1);
    return (v >= m) ? m : v + 32'd1;
  endfunction

endpackage

// File: rtl/range_compare_unit.sv
// range_compare_unit: walks one address window and counts data mismatches.
// Ports: clk/rst; clr wipes state per program; load starts a walk over
// lo..hi; dut_rdata/gold_rdata arrive one cycle after addr; last flags the
// final issued address; err is the saturating mismatch count.
module range_compare_unit
  import prog_check_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int ERR_W  = ADDR_W + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              load,
  input  logic [ADDR_W-1:0] lo,
  input  logic [ADDR_W-1:0] hi,
  input  logic [DATA_W-1:0] dut_rdata,
  input  logic [DATA_W-1:0] gold_rdata,
  output logic [ADDR_W-1:0] addr,
  output logic              last,
  output logic [ERR_W-1:0]  err
);

  // One extra bit so a window ending at the top address cannot wrap.
  logic [ADDR_W:0] cur;
  logic [ADDR_W:0] hi_q;
  logic            active;
  logic            cmp_v;

  assign addr = cur[ADDR_W-1:0];
  assign last = active && (cur >= hi_q);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cur    <= '0;
      hi_q   <= '0;
      active <= 1'b0;
      cmp_v  <= 1'b0;
      err    <= '0;
    end else begin
      // Read data for the address issued last cycle is on the bus now.
      cmp_v <= active;
      if (cmp_v && (dut_rdata != gold_rdata)) begin
        err <= ERR_W'(sat_inc(32'(err), ERR_W));
      end
      if (load) begin
        cur    <= {1'b0, lo};
        hi_q   <= {1'b0, hi};
        active <= 1'b1;
      end else if (active) begin
        if (last) begin
          active <= 1'b0;
        end else begin
          cur <= cur + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/prog_check_sequencer.sv
// prog_check_sequencer: launches NUM_PROGS programs over Start/Ack and
// checks each program's data-memory window against golden memory.
// Ports: Clk/Reset; Go starts a sequence; RangeLo/RangeHi per-program
// windows; Start/Ack DUT handshake; MemAddr, DutRdata, GoldRdata compare
// bus; ProgIdx/Busy/Done/Pass status; ErrCount/RunCycles/TimedOut results.
module prog_check_sequencer
  import prog_check_pkg::*;
#(
  parameter int NUM_PROGS = 3,
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 8,
  parameter int START_CYC = 1,
  parameter int CNT_W     = 16,
  parameter logic [CNT_W-1:0] TIMEOUT = CNT_W'(16'hFFF0),
  parameter int ERR_W     = ADDR_W + 1,
  localparam int PW = (NUM_PROGS > 1) ? $clog2(NUM_PROGS) : 1
) (
  input  logic                      Clk,
  input  logic                      Reset,
  input  logic                      Go,
  input  logic [NUM_PROGS*ADDR_W-1:0] RangeLo,
  input  logic [NUM_PROGS*ADDR_W-1:0] RangeHi,
  output logic                      Start,
  input  logic                      Ack,
  output logic [ADDR_W-1:0]         MemAddr,
  input  logic [DATA_W-1:0]         DutRdata,
  input  logic [DATA_W-1:0]         GoldRdata,
  output logic [PW-1:0]             ProgIdx,
  output logic                      Busy,
  output logic                      Done,
  output logic                      Pass,
  output logic [NUM_PROGS*ERR_W-1:0] ErrCount,
  output logic [NUM_PROGS*CNT_W-1:0] RunCycles,
  output logic [NUM_PROGS-1:0]      TimedOut
);

  seq_state_t           state;
  logic [PW-1:0]        pidx;
  logic [15:0]          lcnt;
  logic [CNT_W-1:0]     rcnt;
  logic                 done_q;
  logic [ERR_W-1:0]     err_a [NUM_PROGS];
  logic [CNT_W-1:0]     run_a [NUM_PROGS];
  logic [NUM_PROGS-1:0] to_q;

  range_t               rng;
  logic                 empty;
  logic                 run_end;
  logic                 err_zero;
  logic                 u_clr;
  logic                 u_load;
  logic                 u_last;
  logic [ERR_W-1:0]     u_err;

  always_comb begin
    rng.lo = RANGE_W'(RangeLo[pidx*ADDR_W +: ADDR_W]);
    rng.hi = RANGE_W'(RangeHi[pidx*ADDR_W +: ADDR_W]);
  end

  assign empty   = rng.hi < rng.lo;
  assign run_end = Ack || (rcnt >= TIMEOUT);
  assign u_clr   = (state == S_LAUNCH);
  // Window is latched on the RUN exit edge, so later edits are ignored.
  assign u_load  = (state == S_RUN) && run_end && !empty;

  range_compare_unit #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .ERR_W  (ERR_W)
  ) u_rcu (
    .clk        (Clk),
    .rst        (Reset),
    .clr        (u_clr),
    .load       (u_load),
    .lo         (rng.lo[ADDR_W-1:0]),
    .hi         (rng.hi[ADDR_W-1:0]),
    .dut_rdata  (DutRdata),
    .gold_rdata (GoldRdata),
    .addr       (MemAddr),
    .last       (u_last),
    .err        (u_err)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state  <= S_IDLE;
      pidx   <= '0;
      lcnt   <= '0;
      rcnt   <= '0;
      done_q <= 1'b0;
      to_q   <= '0;
      for (int i = 0; i < NUM_PROGS; i++) begin
        err_a[i] <= '0;
        run_a[i] <= '0;
      end
    end else begin
      unique case (state)
        S_IDLE: begin
          if (Go) begin
            state  <= S_LAUNCH;
            pidx   <= '0;
            lcnt   <= '0;
            done_q <= 1'b0;
            to_q   <= '0;
            for (int i = 0; i < NUM_PROGS; i++) begin
              err_a[i] <= '0;
              run_a[i] <= '0;
            end
          end
        end
        S_LAUNCH: begin
          if (lcnt == 16'(START_CYC - 1)) begin
            state <= S_RUN;
            rcnt  <= CNT_W'(1);
          end else begin
            lcnt <= lcnt + 16'd1;
          end
        end
        S_RUN: begin
          if (run_end) begin
            run_a[pidx] <= rcnt;
            if (!Ack) begin
              to_q[pidx] <= 1'b1;
            end
            state <= empty ? S_NEXT : S_CHECK;
          end else begin
            rcnt <= CNT_W'(sat_inc(32'(rcnt), CNT_W));
          end
        end
        S_CHECK: begin
          if (u_last) begin
            state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          state <= S_NEXT;
        end
        S_NEXT: begin
          err_a[pidx] <= u_err;
          if (pidx == PW'(NUM_PROGS - 1)) begin
            state <= S_FIN;
          end else begin
            pidx  <= pidx + 1'b1;
            lcnt  <= '0;
            state <= S_LAUNCH;
          end
        end
        S_FIN: begin
          done_q <= 1'b1;
          pidx   <= '0;
          state  <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    err_zero = 1'b1;
    for (int i = 0; i < NUM_PROGS; i++) begin
      if (err_a[i] != '0) begin
        err_zero = 1'b0;
      end
    end
  end

  for (genvar g = 0; g < NUM_PROGS; g++) begin : g_out
    assign ErrCount[g*ERR_W +: ERR_W]  = err_a[g];
    assign RunCycles[g*CNT_W +: CNT_W] = run_a[g];
  end

  assign Start    = (state == S_LAUNCH);
  assign Busy     = (state == S_LAUNCH) || (state == S_RUN) ||
                    (state == S_CHECK) || (state == S_DRAIN) ||
                    (state == S_NEXT);
  assign Done     = (state == S_FIN) || done_q;
  assign Pass     = Done && (to_q == '0) && err_zero;
  assign ProgIdx  = pidx;
  assign TimedOut = to_q;

endmodule

// File: tb/tb_prog_check_sequencer.sv
// tb_prog_check_sequencer: scoreboard bench for prog_check_sequencer.
// Instance 0 uses default parameters, instance 1 uses TIMEOUT=20.
module tb_prog_check_sequencer;

  localparam int NP = 3;
  localparam int AW = 8;
  localparam int DW = 8;
  localparam int CW = 16;
  localparam int EW = AW + 1;
  localparam int PW = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic [1:0] go, start, ack, busy, done, pass;
  logic [1:0][NP*AW-1:0] rlo, rhi;
  logic [1:0][AW-1:0] maddr;
  logic [1:0][DW-1:0] drd, grd;
  logic [1:0][PW-1:0] pidx;
  logic [1:0][NP*EW-1:0] errc;
  logic [1:0][NP*CW-1:0] runc;
  logic [1:0][NP-1:0] tout;

  logic [DW-1:0] dmem [256];
  logic [DW-1:0] gmem [256];
  int  dly   [2][NP];
  bit  never [2][NP];
  bit  stale;
  int  cnt   [2];
  bit  armed [2];

  int nvec = 0;
  int nerr = 0;

  typedef struct {
    string name;
    int inst;
    logic [NP*EW-1:0] err;
    logic [NP*CW-1:0] run;
    logic [NP-1:0] to;
    logic pass;
    int busy;
  } exp_t;
  exp_t sbq[$];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    prog_check_sequencer #(
      .NUM_PROGS (NP),
      .ADDR_W    (AW),
      .DATA_W    (DW),
      .START_CYC (1),
      .CNT_W     (CW),
      .TIMEOUT   ((g == 0) ? 16'hFFF0 : 16'd20),
      .ERR_W     (EW)
    ) u_dut (
      .Clk       (clk),
      .Reset     (rst),
      .Go        (go[g]),
      .RangeLo   (rlo[g]),
      .RangeHi   (rhi[g]),
      .Start     (start[g]),
      .Ack       (ack[g]),
      .MemAddr   (maddr[g]),
      .DutRdata  (drd[g]),
      .GoldRdata (grd[g]),
      .ProgIdx   (pidx[g]),
      .Busy      (busy[g]),
      .Done      (done[g]),
      .Pass      (pass[g]),
      .ErrCount  (errc[g]),
      .RunCycles (runc[g]),
      .TimedOut  (tout[g])
    );
  end

  // Memory read port and program-completion model.
  always @(posedge clk) begin
    for (int g = 0; g < 2; g++) begin
      drd[g] <= dmem[maddr[g]];
      grd[g] <= gmem[maddr[g]];
      if (rst) begin
        armed[g] <= 1'b0;
        cnt[g]   <= 0;
      end else if (start[g]) begin
        armed[g] <= 1'b1;
        cnt[g]   <= 0;
      end else if (armed[g]) begin
        cnt[g] <= cnt[g] + 1;
      end
    end
  end

  // Ack seen in the run cycle whose count equals dly; stays high after.
  always_comb begin
    for (int g = 0; g < 2; g++) begin
      ack[g] = (armed[g] && !start[g] && !never[g][pidx[g]] &&
                (cnt[g] >= dly[g][pidx[g]] - 1)) ||
               (stale && start[g]);
    end
  end

  task automatic chk(input string nm, input longint unsigned act,
                     input longint unsigned exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Monitor: pops an expectation on every Done rising edge.
  bit done_q [2];
  int bcnt   [2];
  always @(negedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (done[g] && !done_q[g]) begin
        if (sbq.size() == 0) begin
          chk($sformatf("unexpected_done%0d", g), 1, 0);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          chk({e.name, "_inst"}, g, e.inst);
          chk({e.name, "_err"}, errc[g], e.err);
          chk({e.name, "_run"}, runc[g], e.run);
          chk({e.name, "_to"}, tout[g], e.to);
          chk({e.name, "_pass"}, pass[g], e.pass);
          chk({e.name, "_busy"}, bcnt[g], e.busy);
        end
      end
      if (busy[g]) bcnt[g]++;
      else bcnt[g] = 0;
      done_q[g] = done[g];
    end
  end

  task automatic chk_zero(input int g, input string t);
    chk({t, "_start"}, start[g], 0);
    chk({t, "_busy"}, busy[g], 0);
    chk({t, "_done"}, done[g], 0);
    chk({t, "_pass"}, pass[g], 0);
    chk({t, "_addr"}, maddr[g], 0);
    chk({t, "_pidx"}, pidx[g], 0);
    chk({t, "_errc"}, errc[g], 0);
    chk({t, "_runc"}, runc[g], 0);
    chk({t, "_tout"}, tout[g], 0);
  endtask

  task automatic setup(input int g, input int lo0, hi0, lo1, hi1,
                       input int lo2, hi2, input int d0, d1, d2,
                       input logic [NP-1:0] nv);
    rlo[g] = {AW'(lo2), AW'(lo1), AW'(lo0)};
    rhi[g] = {AW'(hi2), AW'(hi1), AW'(hi0)};
    dly[g][0] = d0;
    dly[g][1] = d1;
    dly[g][2] = d2;
    for (int i = 0; i < NP; i++) never[g][i] = nv[i];
  endtask

  task automatic run(input int g, input string nm,
                     input int lo0, hi0, lo1, hi1, lo2, hi2,
                     input int d0, d1, d2, input logic [NP-1:0] nv,
                     input int r0, r1, r2, input int e0, e1, e2,
                     input logic [NP-1:0] eto, input logic epass);
    exp_t e;
    int k;
    int lo [3];
    int hi [3];
    int r  [3];
    lo = '{lo0, lo1, lo2};
    hi = '{hi0, hi1, hi2};
    r  = '{r0, r1, r2};
    setup(g, lo0, hi0, lo1, hi1, lo2, hi2, d0, d1, d2, nv);
    e.name = nm;
    e.inst = g;
    e.err  = {EW'(e2), EW'(e1), EW'(e0)};
    e.run  = {CW'(r2), CW'(r1), CW'(r0)};
    e.to   = eto;
    e.pass = epass;
    e.busy = 0;
    for (int i = 0; i < NP; i++) begin
      e.busy += 2 + r[i] + ((hi[i] >= lo[i]) ? (hi[i] - lo[i] + 2) : 0);
    end
    sbq.push_back(e);
    @(negedge clk);
    go[g] = 1'b1;
    @(negedge clk);
    go[g] = 1'b0;
    k = 0;
    while (!done[g] && k < 20000) begin
      @(negedge clk);
      k++;
    end
    if (!done[g]) begin
      chk({nm, "_done_timeout"}, done[g], 1);
      void'(sbq.pop_back());
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int k;
    rst   = 1'b1;
    go    = '0;
    stale = 1'b0;
    rlo   = '0;
    rhi   = '0;
    for (int i = 0; i < 256; i++) begin
      dmem[i] = DW'(i * 37 + 11);
      gmem[i] = DW'(i * 37 + 11);
    end
    for (int g = 0; g < 2; g++) setup(g, 0, 0, 0, 0, 0, 0, 50, 50, 50, '0);
    repeat (3) @(negedge clk);
    chk_zero(0, "rst0");
    chk_zero(1, "rst1");
    rst = 1'b0;
    repeat (2) @(negedge clk);

    run(0, "dflt", 30, 59, 94, 123, 192, 194, 50, 50, 50, '0,
        50, 50, 50, 0, 0, 0, 3'b000, 1'b1);

    gmem[31]  = gmem[31] ^ 8'h01;
    gmem[59]  = gmem[59] ^ 8'h80;
    gmem[193] = gmem[193] ^ 8'h10;
    run(0, "miscmp", 30, 59, 94, 123, 192, 194, 50, 50, 50, '0,
        50, 50, 50, 2, 0, 1, 3'b000, 1'b0);
    gmem[31]  = dmem[31];
    gmem[59]  = dmem[59];
    gmem[193] = dmem[193];

    stale = 1'b1;
    run(0, "stale", 30, 59, 94, 123, 192, 194, 50, 10, 50, '0,
        50, 10, 50, 0, 0, 0, 3'b000, 1'b1);
    stale = 1'b0;

    run(1, "tmo", 30, 59, 94, 123, 192, 194, 12, 0, 15, 3'b010,
        12, 20, 15, 0, 0, 0, 3'b010, 1'b0);

    gmem[255] = gmem[255] ^ 8'h04;
    gmem[0]   = gmem[0] ^ 8'h40;
    run(0, "bound", 255, 255, 5, 4, 0, 255, 5, 6, 7, '0,
        5, 6, 7, 1, 0, 2, 3'b000, 1'b0);
    gmem[255] = dmem[255];
    gmem[0]   = dmem[0];

    setup(0, 30, 59, 94, 123, 192, 194, 50, 50, 50, '0);
    @(negedge clk);
    go[0] = 1'b1;
    @(negedge clk);
    go[0] = 1'b0;
    k = 0;
    while (runc[0][2*CW-1:CW] == 0 && k < 2000) begin
      @(negedge clk);
      k++;
    end
    chk("mid_run1", runc[0][2*CW-1:CW], 50);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk_zero(0, "midrst");
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    run(0, "rerun", 30, 59, 94, 123, 192, 194, 50, 50, 50, '0,
        50, 50, 50, 0, 0, 0, 3'b000, 1'b1);

    repeat (3) @(negedge clk);
    chk("queue_empty", sbq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
